instr_loader: RTL

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 32 +++
 rtl/instr_word_reg.sv | 28 ++
 rtl/instr_loader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader: FSM states, field
// widths, address step and the packing of an instruction field set into a word.
package instr_loader_pkg;

  localparam int OP_W   = 6;
  localparam int RS_W   = 5;
  localparam int RT_W   = 5;
  localparam int IMM_W  = 16;
  localparam int WORD_W = OP_W + RS_W + RT_W + IMM_W;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 8;

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Opcode lands in the top bits, immediate in the bottom bits.
  function automatic logic [WORD_W-1:0] pack_instr(
    input logic [OP_W-1:0]  op,
    input logic [RS_W-1:0]  rs,
    input logic [RT_W-1:0]  rt,
    input logic [IMM_W-1:0] imm
  );
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_word_reg.sv
// Load-enabled register holding the packed instruction word that drives the
// instruction-memory write data bus.
module instr_word_reg
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_word,
  output logic [WORD_W-1:0] o_word
);

  logic [WORD_W-1:0] r_word;

  // NOTE: non-blocking (<=) for every flop so all registers update together at
  // the edge. This register is reset because its value is directly visible on
  // mem_wdata and must read as zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word <= '0;
    end else if (i_load) begin
      r_word <= i_word;
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/instr_loader.sv
// Instruction-memory burst loader: accepts field sets, packs them into words and
// writes them to consecutive word addresses. Optional running XOR checksum is
// built only when INSTR_LOADER_CHECKSUM_EN is defined.
module instr_loader
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   Instr31to26,
  input  logic [RS_W-1:0]   Instr25to21,
  input  logic [RT_W-1:0]   Instr20to16,
  input  logic [IMM_W-1:0]  Instr15to0,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  loaded_count,
  output logic [WORD_W-1:0] checksum
);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_loaded_count;
  logic [CNT_W-1:0]  w_loaded_inc;
  logic              w_start;
  logic              w_accept;
  logic              w_write;
  logic              w_last;
  logic [WORD_W-1:0] w_packed;
  logic [WORD_W-1:0] w_word;

  assign w_start      = (r_state == IDLE) && start;
  assign w_accept     = (r_state == LOAD) && in_valid;
  assign w_write      = (r_state == WRITE);
  assign w_loaded_inc = r_loaded_count + CNT_W'(1);
  assign w_last       = (w_loaded_inc == r_count);
  assign w_packed     = pack_instr(Instr31to26, Instr25to21, Instr20to16, Instr15to0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    mem_write    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next_state = (count == '0) ? FIN : LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = WRITE;
        end
      end
      WRITE: begin
        mem_write    = 1'b1;
        w_next_state = w_last ? FIN : LOAD;
      end
      FIN: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Address and count advance as WRITE is left, so mem_addr stays stable while
  // the strobe is high; the address add wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr         <= '0;
      r_count        <= '0;
      r_loaded_count <= '0;
    end else if (w_start) begin
      r_addr         <= base_addr;
      r_count        <= count;
      r_loaded_count <= '0;
    end else if (w_write) begin
      r_addr         <= r_addr + ADDR_STEP;
      r_loaded_count <= w_loaded_inc;
    end
  end

  instr_word_reg u_word_reg (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_accept),
    .i_word (w_packed),
    .o_word (w_word)
  );

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] r_checksum;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_start) begin
      r_checksum <= '0;
    end else if (w_write) begin
      r_checksum <= r_checksum ^ w_word;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign mem_addr     = r_addr;
  assign mem_wdata    = w_word;
  assign loaded_count = r_loaded_count;

endmodule
